i2s_rx: RTL and testbench
=========================

// Module: i2s_rx
// PURPOSE
//  I2S slave receiver for the PMOD I2S2 line-in (ADC) path: the capture-side counterpart of the
//  playback I2S transmitter. Oversamples externally driven SCK/WS/SDATA in the clk_i domain,
//  deserialises MSB-first stereo words, and queues {left,right} frames in a small FIFO.
//  Firmware or the audio DMA drains frames over a valid/accept handshake.
// PARAMETERS
//  SAMPLE_W     16  captured bits per channel (MSB-first; extra bits dropped, short words zero-padded)
//  FIFO_DEPTH   4   frame FIFO entries, power of 2, >=2
//  SYNC_STAGES  2   synchroniser flops on each I2S input, >=2
// PORTS
//  clk_i            in   1           system clock; all logic on rising edge
//  rst_n_i          in   1           reset, synchronous, active-low
//  enable_i         in   1           1 = receive; 0 = FSM to IDLE, partial words discarded
//  i2s_sck_i        in   1           bit clock from codec (async, <= clk_i/4)
//  i2s_ws_i         in   1           word select (0 = left, 1 = right), async
//  i2s_sdata_i      in   1           serial data, async
//  sample_valid_o   out  1           FIFO head frame available
//  sample_data_o    out  2*SAMPLE_W  {left, right} of FIFO head
//  sample_accept_i  in   1           pop head when sample_valid_o & sample_accept_i
//  level_o          out  log2(FIFO_DEPTH)+1  current FIFO occupancy
//  overflow_o       out  1           sticky: frame dropped on full FIFO; cleared while enable_i=0
// BEHAVIOUR
//  - Reset: all outputs 0; FIFO empty; FSM IDLE; shift regs, bit counters, ws_d = 0.
//  - Inputs pass SYNC_STAGES flops (sck_s, ws_s, sd_s); SCK rise = sck_s & ~sck_s_q (one-cycle pulse).
//  - On each rise: bit = sd_s belongs to channel ws_d (WS captured on previous rise, models the
//    1-SCK I2S delay). If that channel's bit_cnt < SAMPLE_W, write bit at position SAMPLE_W-1-bit_cnt;
//    bit_cnt saturates at SAMPLE_W. Then ws_d <= ws_s.
//  - Channel boundary = rise with ws_s != ws_d: the bit on that rise is the last bit of channel ws_d;
//    after storing it, the other channel's shift reg and bit_cnt clear (unwritten LSBs stay 0).
//  - FSM: IDLE -(enable_i)-> ALIGN -(rise with ws_d=1, ws_s=0)-> RUN. RUN -(~enable_i)-> IDLE.
//    ALIGN drops all bits; the first frame captured is the first full left word.
//  - Push: in RUN, on rise with ws_d=1 & ws_s=0 (right word complete) write {left,right}
//    into FIFO that cycle; sample_valid_o visible next cycle (latency from that SCK-rise detect = 1 clk).
//  - Full on push: frame dropped, FIFO unchanged, overflow_o <= 1 next cycle. Push and pop in same
//    cycle with FIFO full: pop frees slot, push accepted (level unchanged).
//  - Pop with empty FIFO ignored. sample_data_o stable while valid & ~accept.
//  - enable_i 0 mid-word: FSM IDLE next cycle, counters/shift regs cleared, FIFO retained and still
//    drainable; overflow_o cleared. Re-enable restarts at ALIGN.
//  - rst_n_i low mid-frame: all state to reset values at that clock edge, FIFO contents lost.
//  - Read/write pointers are log2(FIFO_DEPTH)+1 bits, wrap naturally; full = MSBs differ, low bits equal.
// STRUCTURE
//  - Package i2s_pkg: WS_LEFT=0/WS_RIGHT=1, FSM state encoding (IDLE, ALIGN, RUN), shared with i2s tx.
//  - Sub-module i2s_rx_fifo: generic sync FIFO (WIDTH, DEPTH), push/pop/valid/level; rest in i2s_rx.
// TESTING
//  - SAMPLE_W=16, 64-SCK frames, L=0xA5C3 R=0x0F0F, 3 frames -> 2 frames {0xA5C3,0x0F0F} after first
//    (ALIGN) frame, level_o 1 then 2, no overflow.
//  - 32-SCK frames (16 bits exact) L=0x8001 R=0x7FFE; and 24-SCK frames (12 bits) L=0xFFF, R=0x000 ->
//    {0x8001,0x7FFE}; {0xFFF0,0x0000} (zero-padded LSBs).
//  - No accept, 6 frames, FIFO_DEPTH=4 -> level_o=4, overflow_o=1 after 5th; drained data = frames 1-4.
//  - Full FIFO, sample_accept_i held 1 in same cycle as push -> level_o stays 4, no overflow.
//  - enable_i drop mid-left-word, re-enable -> no partial frame, next full frame captured correctly,
//    overflow_o cleared; rst_n_i pulse mid-frame -> valid=0, level_o=0 next cycle.
//  - Random SCK/clk_i phase (ratios 4..16) vs reference model -> bit-exact frames.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared I2S definitions: word-select polarity and the receive/transmit FSM encoding.
package i2s_pkg;

   localparam logic WS_LEFT  = 1'b0;
   localparam logic WS_RIGHT = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ALIGN = 2'd1,
      ST_RUN   = 2'd2
   } i2s_state_e;

endpackage

// File: rtl/i2s_rx_fifo.sv
// Generic synchronous FIFO with extra-MSB pointers; head word is presented combinationally.
module i2s_rx_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic                     valid_o,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]                  wptr_q, wptr_d, rptr_q, rptr_d;
   logic [DEPTH-1:0][WIDTH-1:0]  mem_q, mem_d;
   logic                         empty, full, do_push, do_pop;

   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   // A pop in the same cycle frees the slot the push is about to use.
   assign do_pop  = pop_i & ~empty;
   assign do_push = push_i & (~full | do_pop);

   always_comb begin
      mem_d  = mem_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (do_push) begin
         mem_d[wptr_q[AW-1:0]] = wdata_i;
         wptr_d = wptr_q + 1'b1;
      end
      if (do_pop) begin
         rptr_d = rptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         mem_q  <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         mem_q  <= mem_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   assign valid_o = ~empty;
   assign rdata_o = empty ? '0 : mem_q[rptr_q[AW-1:0]];
   assign full_o  = full;
   assign level_o = wptr_q - rptr_q;

endmodule

// File: rtl/i2s_rx.sv
// I2S slave receiver: oversamples SCK/WS/SDATA, deserialises MSB-first stereo words
// and queues {left,right} frames for a valid/accept consumer.
module i2s_rx
   import i2s_pkg::*;
#(
   parameter int SAMPLE_W    = 16,
   parameter int FIFO_DEPTH  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                          clk_i,
   input  logic                          rst_n_i,
   input  logic                          enable_i,
   input  logic                          i2s_sck_i,
   input  logic                          i2s_ws_i,
   input  logic                          i2s_sdata_i,
   output logic                          sample_valid_o,
   output logic [2*SAMPLE_W-1:0]         sample_data_o,
   input  logic                          sample_accept_i,
   output logic [$clog2(FIFO_DEPTH):0]   level_o,
   output logic                          overflow_o
);

   localparam int                CNT_W   = $clog2(SAMPLE_W + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(SAMPLE_W);
   localparam logic [CNT_W-1:0]  MSB_POS = CNT_W'(SAMPLE_W - 1);
   localparam logic [SAMPLE_W-1:0] ONE   = SAMPLE_W'(1);

   logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d, ws_sync_q, ws_sync_d, sd_sync_q, sd_sync_d;
   logic                   sck_prev_q, ws_dly_q, ws_dly_d, ovf_q, ovf_d;
   logic [SAMPLE_W-1:0]    left_q, left_d, right_q, right_d;
   logic [CNT_W-1:0]       lcnt_q, lcnt_d, rcnt_q, rcnt_d;
   i2s_state_e             state_q, state_d;
   logic                   sck_s, ws_s, sd_s, rise, push, fifo_full;

   assign sck_s = sck_sync_q[SYNC_STAGES-1];
   assign ws_s  = ws_sync_q[SYNC_STAGES-1];
   assign sd_s  = sd_sync_q[SYNC_STAGES-1];
   assign rise  = sck_s & ~sck_prev_q;

   always_comb begin
      sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], i2s_sck_i};
      ws_sync_d  = {ws_sync_q[SYNC_STAGES-2:0], i2s_ws_i};
      sd_sync_d  = {sd_sync_q[SYNC_STAGES-2:0], i2s_sdata_i};
      state_d  = state_q;
      ws_dly_d = ws_dly_q;
      left_d   = left_q;
      right_d  = right_q;
      lcnt_d   = lcnt_q;
      rcnt_d   = rcnt_q;
      ovf_d    = ovf_q;
      push     = 1'b0;
      if (!enable_i) begin
         state_d  = ST_IDLE;
         ws_dly_d = 1'b0;
         left_d   = '0;
         right_d  = '0;
         lcnt_d   = '0;
         rcnt_d   = '0;
         ovf_d    = 1'b0;
      end else if (state_q == ST_IDLE) begin
         state_d = ST_ALIGN;
      end else if (rise) begin
         // The bit on this rise belongs to the channel selected one SCK earlier.
         if (ws_dly_q == WS_LEFT) begin
            if (lcnt_q < CNT_MAX) begin
               if (sd_s) left_d = left_q | (ONE << (MSB_POS - lcnt_q));
               lcnt_d = lcnt_q + 1'b1;
            end
         end else if (rcnt_q < CNT_MAX) begin
            if (sd_s) right_d = right_q | (ONE << (MSB_POS - rcnt_q));
            rcnt_d = rcnt_q + 1'b1;
         end
         if (ws_s != ws_dly_q) begin
            if (ws_dly_q == WS_LEFT) begin
               right_d = '0;
               rcnt_d  = '0;
            end else begin
               left_d = '0;
               lcnt_d = '0;
            end
         end
         if (ws_dly_q == WS_RIGHT && ws_s == WS_LEFT) begin
            if (state_q == ST_ALIGN) state_d = ST_RUN;
            else                     push    = 1'b1;
         end
         ws_dly_d = ws_s;
      end
      if (push && fifo_full && !sample_accept_i) ovf_d = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         sck_sync_q <= '0;
         ws_sync_q  <= '0;
         sd_sync_q  <= '0;
         sck_prev_q <= 1'b0;
         state_q    <= ST_IDLE;
         ws_dly_q   <= 1'b0;
         left_q     <= '0;
         right_q    <= '0;
         lcnt_q     <= '0;
         rcnt_q     <= '0;
         ovf_q      <= 1'b0;
      end else begin
         sck_sync_q <= sck_sync_d;
         ws_sync_q  <= ws_sync_d;
         sd_sync_q  <= sd_sync_d;
         sck_prev_q <= sck_s;
         state_q    <= state_d;
         ws_dly_q   <= ws_dly_d;
         left_q     <= left_d;
         right_q    <= right_d;
         lcnt_q     <= lcnt_d;
         rcnt_q     <= rcnt_d;
         ovf_q      <= ovf_d;
      end
   end

   i2s_rx_fifo #(.WIDTH(2*SAMPLE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .push_i  (push),
      .wdata_i ({left_q, right_d}),
      .pop_i   (sample_accept_i),
      .valid_o (sample_valid_o),
      .rdata_o (sample_data_o),
      .full_o  (fifo_full),
      .level_o (level_o)
   );

   assign overflow_o = ovf_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Self-checking bench for i2s_rx: an I2S master model drives frames, expected frames
// go into a scoreboard queue, and a monitor pops/compares on every accepted output.
module tb_i2s_rx;

   logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
   logic        sck = 1'b0, ws = 1'b0, sd = 1'b0, accept = 1'b0;
   logic        valid, ovf;
   logic [31:0] data;
   logic [2:0]  level;

   int          errors = 0, checks = 0;
   logic [31:0] exp_q[$];
   logic        acc_rand = 1'b0, force_acc = 1'b0, nxt_sd = 1'b0;
   int          lo = 4, hi = 4;

   i2s_rx #(.SAMPLE_W(16), .FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
      .clk_i           (clk),
      .rst_n_i         (rst_n),
      .enable_i        (enable),
      .i2s_sck_i       (sck),
      .i2s_ws_i        (ws),
      .i2s_sdata_i     (sd),
      .sample_valid_o  (valid),
      .sample_data_o   (data),
      .sample_accept_i (accept),
      .level_o         (level),
      .overflow_o      (ovf)
   );

   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Captured word = first 16 transmitted bits, MSB-first; short words zero-padded.
   function automatic logic [15:0] expw(input logic [31:0] w, input int n);
      logic [15:0] m;
      m = 16'hFFFF;
      if (n < 16) m = m << (16 - n);
      return w[31:16] & m;
   endfunction

   // Monitor: decides accept for the coming edge, and compares whenever a pop will happen.
   always @(negedge clk) begin : monitor
      logic a;
      a = force_acc | (acc_rand & 1'($urandom_range(0, 1)));
      accept = a;
      if (a && valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL frame: got %h expected no frame", data);
         end else begin
            chk("frame", data, exp_q.pop_front());
         end
      end
   end

   // One I2S frame of n bits per channel; words are left-justified in 32 bits.
   // evt: 1 = drop enable after rise of period evt_at, 2 = reset pulse there.
   task automatic send_frame(input int n, input logic [31:0] l, input logic [31:0] r,
                             input bit cap, input int evt_at, input int evt);
      logic [31:0] t;
      if (cap) exp_q.push_back({expw(l, n), expw(r, n)});
      for (int p = 0; p < 2 * n; p++) begin
         sck = 1'b0;
         ws  = (p >= n);
         sd  = nxt_sd;
         repeat (lo) @(posedge clk);
         #1 sck = 1'b1;
         t = (p < n) ? (l << p) : (r << (p - n));
         nxt_sd = t[31];
         if (p == evt_at && evt == 1) begin
            enable = 1'b0;
            @(negedge clk);
            @(negedge clk);
            chk("ovf_clr_on_disable", 32'(ovf), 0);
            @(posedge clk);
            #1 enable = 1'b1;
         end else if (p == evt_at && evt == 2) begin
            @(negedge clk);
            chk("lvl_before_reset", 32'(level), 1);
            @(posedge clk);
            #1 rst_n = 1'b0;
            @(posedge clk);
            #1 rst_n = 1'b1;
            exp_q.delete();
            @(negedge clk);
            chk("valid_after_reset", 32'(valid), 0);
            chk("lvl_after_reset", 32'(level), 0);
         end
         repeat (hi) @(posedge clk);
         #1;
      end
   endtask

   // Closing period (WS back to left) so the last right word completes.
   // With frc, accept is held exactly in the cycle the push lands (2 sync stages + detect).
   task automatic send_tail(input bit frc);
      sck = 1'b0;
      ws  = 1'b0;
      sd  = nxt_sd;
      repeat (lo) @(posedge clk);
      #1 sck = 1'b1;
      if (frc) begin
         @(posedge clk);
         @(posedge clk);
         #1 force_acc = 1'b1;
         @(posedge clk);
         #1 force_acc = 1'b0;
         repeat (hi - 3) @(posedge clk);
      end else begin
         repeat (hi) @(posedge clk);
      end
      #1 nxt_sd = 1'b0;
      repeat (6) @(posedge clk);
   endtask

   task automatic start(input int ratio);
      enable = 1'b0;
      repeat (3) @(posedge clk);
      lo = ratio - ratio / 2;
      hi = ratio / 2;
      #1 enable = 1'b1;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      int t;
      t = 0;
      acc_rand = 1'b1;
      while ((exp_q.size() != 0 || valid) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      acc_rand = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk({name, "_lvl_empty"}, 32'(level), 0);
      chk({name, "_sb_empty"}, exp_q.size(), 0);
   endtask

   initial begin
      int nl[6];
      int n;
      nl = '{8, 12, 16, 20, 24, 32};
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", 32'(valid), 0);
      chk("rst_data", data, 0);
      chk("rst_level", 32'(level), 0);
      chk("rst_ovf", 32'(ovf), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // 64-SCK frames: extra LSBs dropped, level 1 then 2
      start(8);
      send_frame(32, {16'hA5C3, 16'($urandom)}, {16'h0F0F, 16'($urandom)}, 0, -1, 0);
      send_frame(32, {16'hA5C3, 16'($urandom)}, {16'h0F0F, 16'($urandom)}, 1, -1, 0);
      send_frame(32, {16'hA5C3, 16'($urandom)}, {16'h0F0F, 16'($urandom)}, 1, -1, 0);
      @(negedge clk);
      chk("t1_level1", 32'(level), 1);
      send_tail(0);
      @(negedge clk);
      chk("t1_level2", 32'(level), 2);
      chk("t1_ovf", 32'(ovf), 0);
      drain("t1");

      // exact 16-bit words with random accept
      start(8);
      acc_rand = 1'b1;
      for (int i = 0; i < 3; i++) send_frame(16, 32'h8001_0000, 32'h7FFE_0000, i > 0, -1, 0);
      send_tail(0);
      drain("t2");

      // 12-bit words: LSBs zero-padded
      start(8);
      for (int i = 0; i < 3; i++) send_frame(12, 32'hFFF0_0000, 32'h0, i > 0, -1, 0);
      send_tail(0);
      drain("t3");

      // overflow: 6 frames with no accept, only the first 4 survive
      start(6);
      for (int i = 0; i < 7; i++) send_frame(16, $urandom, $urandom, (i > 0) && (i < 5), -1, 0);
      send_tail(0);
      @(negedge clk);
      chk("t4_level_full", 32'(level), 4);
      chk("t4_ovf_set", 32'(ovf), 1);
      drain("t4");
      chk("t4_ovf_sticky", 32'(ovf), 1);

      // enable drop mid-left-word, re-enable: next full frames captured
      send_frame(16, $urandom, $urandom, 0, 5, 1);
      send_frame(16, $urandom, $urandom, 1, -1, 0);
      send_frame(16, $urandom, $urandom, 1, -1, 0);
      send_tail(0);
      drain("t5");

      // full FIFO with pop in the push cycle: level stays 4, no overflow
      start(8);
      for (int i = 0; i < 6; i++) send_frame(16, $urandom, $urandom, i > 0, -1, 0);
      @(negedge clk);
      chk("t6_level_full", 32'(level), 4);
      chk("t6_ovf_before", 32'(ovf), 0);
      send_tail(1);
      @(negedge clk);
      chk("t6_level_kept", 32'(level), 4);
      chk("t6_ovf_after", 32'(ovf), 0);
      drain("t6");

      // random SCK ratios and word lengths
      for (int k = 0; k < 6; k++) begin
         n = nl[$urandom_range(0, 5)];
         start($urandom_range(4, 16));
         acc_rand = 1'b1;
         for (int i = 0; i < 4; i++) send_frame(n, $urandom, $urandom, i > 0, -1, 0);
         send_tail(0);
         drain("t7");
      end

      // reset pulse mid-frame loses FIFO contents
      start(8);
      send_frame(16, $urandom, $urandom, 0, -1, 0);
      send_frame(16, $urandom, $urandom, 1, -1, 0);
      send_frame(16, $urandom, $urandom, 0, 3, 2);
      send_tail(0);
      @(negedge clk);
      chk("t8_level", 32'(level), 0);
      chk("t8_valid", 32'(valid), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
